// File: rtl/coor_transmitter_pkg.sv
// Shared types and widths for the polygon-vertex transmitter.
package coor_transmitter_pkg;

  localparam int COOR_W = 9;            // one coordinate
  localparam int CNT_W  = 7;            // vertex counts / indices
  localparam int VTX_W  = 2 * COOR_W;   // packed {x, y} buffer entry

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESENT  = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  // A transfer needs at least two vertices and must fit in the buffer.
  function automatic logic num_ok(input logic [CNT_W-1:0] n, input int depth);
    return (n >= CNT_W'(2)) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/coor_buffer.sv
// Vertex store: DEPTH x {x, y}, one synchronous write port, one combinational read port.
module coor_buffer
  import coor_transmitter_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [VTX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [VTX_W-1:0]  rdata
);

  logic [VTX_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset so a reset keeps the loaded polygon.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Addresses past DEPTH (non power-of-two depths) read as zero.
  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/coor_transmitter.sv
// Presents buffered polygon vertices one at a time to the receiver, advancing on
// each rising edge of tranFlag, with a watchdog on the acknowledge handshake.
module coor_transmitter
  import coor_transmitter_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              Sender_clk,
  input  logic              Sender_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COOR_W-1:0] wr_x,
  input  logic [COOR_W-1:0] wr_y,
  input  logic [CNT_W-1:0]  num,
  input  logic              start,
  input  logic              clr,
  input  logic              tranFlag,
  output logic [CNT_W-1:0]  coorQ,
  output logic [COOR_W-1:0] coorX,
  output logic [COOR_W-1:0] coorY,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  idx_q;
  logic [TMR_W-1:0]  timer_q;
  logic              ack_q;

  logic              ack_edge;
  logic              timer_expired;
  logic              buf_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [VTX_W-1:0]  rd_data;
  logic [VTX_W-1:0]  first_vtx;

  assign ack_edge      = tranFlag & ~ack_q;
  assign timer_expired = (timer_q == TMR_W'(TIMEOUT - 1));
  assign buf_we        = wr_en & (state_q == ST_IDLE);
  // In IDLE the read port looks at vertex 0; while transferring it looks one ahead.
  assign rd_addr       = (state_q == ST_IDLE) ? '0 : ADDR_W'(idx_q + CNT_W'(1));
  // Forward a same-cycle write to entry 0 so start sees it.
  assign first_vtx     = (buf_we && (wr_addr == '0)) ? {wr_x, wr_y} : rd_data;

  coor_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (Sender_clk),
    .we    (buf_we),
    .waddr (wr_addr),
    .wdata ({wr_x, wr_y}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Transfer FSM with acknowledge edge detector, watchdog timer and registered outputs.
  always_ff @(posedge Sender_clk or negedge Sender_rst) begin
    if (!Sender_rst) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      ack_q    <= 1'b0;
      coorQ    <= '0;
      coorX    <= '0;
      coorY    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sent_cnt <= '0;
    end else begin
      ack_q <= tranFlag;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_ok(num, DEPTH)) begin
              num_q    <= num;
              idx_q    <= '0;
              timer_q  <= '0;
              sent_cnt <= '0;
              coorQ    <= num;
              coorX    <= first_vtx[VTX_W-1:COOR_W];
              coorY    <= first_vtx[COOR_W-1:0];
              busy     <= 1'b1;
              state_q  <= ST_PRESENT;
            end else begin
              err     <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_PRESENT: begin
          if (ack_edge) begin
            sent_cnt <= sent_cnt + CNT_W'(1);
            timer_q  <= '0;
            if (idx_q == num_q - CNT_W'(1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + CNT_W'(1);
              coorX   <= rd_data[VTX_W-1:COOR_W];
              coorY   <= rd_data[COOR_W-1:0];
              state_q <= ST_WAIT_LOW;
            end
          end else if (timer_expired) begin
            timer_q <= TMR_W'(TIMEOUT);
            coorQ   <= '0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_WAIT_LOW: begin
          // The timer keeps running so a stuck-high acknowledge still times out.
          if (timer_expired) begin
            timer_q <= TMR_W'(TIMEOUT);
            coorQ   <= '0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (!tranFlag) begin
              state_q <= ST_PRESENT;
            end
          end
        end
        ST_DONE: begin
          if (clr) begin
            coorQ    <= '0;
            sent_cnt <= '0;
            done     <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (clr) begin
            sent_cnt <= '0;
            err      <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coor_transmitter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the vertex transfer.
module tb_coor_transmitter;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 255;

  localparam int M_IDLE = 0;
  localparam int M_XFER = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic              Sender_clk = 1'b0;
  logic              Sender_rst = 1'b0;
  logic              wr_en      = 1'b0;
  logic [ADDR_W-1:0] wr_addr    = '0;
  logic [8:0]        wr_x       = '0;
  logic [8:0]        wr_y       = '0;
  logic [6:0]        num        = '0;
  logic              start      = 1'b0;
  logic              clr        = 1'b0;
  logic              tranFlag   = 1'b0;
  logic [6:0]        coorQ;
  logic [8:0]        coorX;
  logic [8:0]        coorY;
  logic              busy;
  logic              done;
  logic              err;
  logic [6:0]        sent_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  coor_transmitter #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Sender_clk (Sender_clk),
    .Sender_rst (Sender_rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .num        (num),
    .start      (start),
    .clr        (clr),
    .tranFlag   (tranFlag),
    .coorQ      (coorQ),
    .coorX      (coorX),
    .coorY      (coorY),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sent_cnt   (sent_cnt)
  );

  always #5 Sender_clk = ~Sender_clk;

  // ---------------- reference model ----------------
  // mode, vertices acknowledged so far, whether the receiver must drop tranFlag
  // before the next acknowledge counts, and quiet cycles since the last acknowledge.
  typedef struct {
    int mode;
    int num;
    int sent;
    bit need_low;
    int quiet;
    bit prev;
  } mdl_t;

  mdl_t       m = '{mode: M_IDLE, num: 0, sent: 0, need_low: 1'b0, quiet: 0, prev: 1'b0};
  logic [17:0] mmem [DEPTH];

  function automatic mdl_t step(mdl_t s);
    mdl_t r;
    bit   ev;
    r  = s;
    ev = tranFlag && !s.prev;
    case (s.mode)
      M_IDLE: if (start) begin
        if (num >= 2 && num <= DEPTH) begin
          r.mode = M_XFER; r.num = int'(num); r.sent = 0; r.need_low = 1'b0; r.quiet = 0;
        end else begin
          r.mode = M_ERR;
        end
      end
      M_XFER: begin
        if (!s.need_low && ev) begin
          r.sent  = s.sent + 1;
          r.quiet = 0;
          if (r.sent == s.num) r.mode = M_DONE;
          else r.need_low = 1'b1;
        end else begin
          r.quiet = s.quiet + 1;
          if (r.quiet >= TIMEOUT) r.mode = M_ERR;
          else if (s.need_low && !tranFlag) r.need_low = 1'b0;
        end
      end
      default: if (clr) begin
        r.mode = M_IDLE;
        r.sent = 0;
      end
    endcase
    r.prev = tranFlag;
    return r;
  endfunction

  always @(posedge Sender_clk or negedge Sender_rst) begin
    if (!Sender_rst) begin
      m <= '{mode: M_IDLE, num: 0, sent: 0, need_low: 1'b0, quiet: 0, prev: 1'b0};
    end else begin
      if (m.mode == M_IDLE && wr_en) mmem[wr_addr] <= {wr_x, wr_y};
      m <= step(m);
    end
  end

  function automatic logic [17:0] exp_vtx();
    if (m.mode == M_XFER) return mmem[m.sent];
    return mmem[m.num - 1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Sender_clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m.mode == M_XFER));
      chk("done", int'(done), int'(m.mode == M_DONE));
      chk("err", int'(err), int'(m.mode == M_ERR));
      chk("sent_cnt", int'(sent_cnt), m.sent);
      chk("coorQ", int'(coorQ), (m.mode == M_XFER || m.mode == M_DONE) ? m.num : 0);
      if (m.mode == M_XFER || m.mode == M_DONE) begin
        chk("coorX", int'(coorX), int'(exp_vtx() >> 9));
        chk("coorY", int'(coorY), int'(exp_vtx() & 18'h1FF));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Sender_clk);
    #1;
  endtask

  task automatic write_vtx(input int a, input int x, input int y);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_x = 9'(x); wr_y = 9'(y);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num = 7'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pulse(input int hold, input int gap);
    tranFlag = 1'b1;
    repeat (hold) tick();
    tranFlag = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vx [4];
    int vy [4];
    vx = '{0, 10, 10, 0};
    vy = '{0, 0, 10, 10};

    repeat (3) tick();
    chk("rst_coorQ", int'(coorQ), 0);
    chk("rst_busy", int'(busy), 0);
    Sender_rst = 1'b1;
    tick();
    chk_en = 1'b1;

    // Square polygon, single-cycle acknowledges.
    for (int i = 0; i < 4; i++) write_vtx(i, vx[i], vy[i]);
    do_start(4);
    chk("t1_first_x", int'(coorX), 0);
    chk("t1_first_y", int'(coorY), 0);
    chk("t1_coorQ", int'(coorQ), 4);
    for (int i = 0; i < 4; i++) begin
      pulse(1, 2);
      chk("t1_x", int'(coorX), vx[(i < 3) ? i + 1 : 3]);
      chk("t1_y", int'(coorY), vy[(i < 3) ? i + 1 : 3]);
    end
    pulse(1, 3);
    chk("t1_done", int'(done), 1);
    chk("t1_sent", int'(sent_cnt), 4);
    chk("t1_hold_q", int'(coorQ), 4);
    chk("t1_hold_x", int'(coorX), 0);
    chk("t1_hold_y", int'(coorY), 10);
    do_clr();
    chk("t1_clr_q", int'(coorQ), 0);

    // Long acknowledges: one advance per high period.
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      pulse(5, 2);
      chk("t2_sent", int'(sent_cnt), i + 1);
    end
    chk("t2_done", int'(done), 1);
    do_clr();

    // Illegal vertex counts.
    do_start(1);
    chk("t3_err_lo", int'(err), 1);
    chk("t3_q_lo", int'(coorQ), 0);
    do_clr();
    chk("t3_clr", int'(err), 0);
    do_start(DEPTH + 1);
    chk("t3_err_hi", int'(err), 1);
    do_clr();

    // Receiver stalls after the second acknowledge.
    do_start(3);
    pulse(1, 2);
    pulse(1, 2);
    for (int i = 0; i < 400 && !err; i++) tick();
    chk("t4_err", int'(err), 1);
    chk("t4_q", int'(coorQ), 0);
    chk("t4_sent", int'(sent_cnt), 2);
    do_clr();

    // Asynchronous reset mid-transfer, buffer survives.
    do_start(3);
    pulse(1, 2);
    #2 Sender_rst = 1'b0;
    #1;
    chk("t5_rst_q", int'(coorQ), 0);
    chk("t5_rst_x", int'(coorX), 0);
    chk("t5_rst_y", int'(coorY), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_sent", int'(sent_cnt), 0);
    @(posedge Sender_clk);
    #1 Sender_rst = 1'b1;
    tick();
    do_start(3);
    repeat (3) pulse(1, 1);
    chk("t5_done", int'(done), 1);
    chk("t5_last_x", int'(coorX), 10);
    chk("t5_last_y", int'(coorY), 10);

    // Writes outside IDLE are dropped; same-cycle write+start is forwarded.
    write_vtx(0, 99, 99);
    do_clr();
    do_start(4);
    chk("t6_first_x", int'(coorX), 0);
    chk("t6_first_y", int'(coorY), 0);
    repeat (4) pulse(1, 1);
    do_clr();
    wr_en = 1'b1; wr_addr = '0; wr_x = 9'd55; wr_y = 9'd77;
    start = 1'b1; num = 7'd2;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("t6_fwd_x", int'(coorX), 55);
    chk("t6_fwd_y", int'(coorY), 77);
    repeat (2) pulse(1, 1);
    chk("t6_done", int'(done), 1);
    do_clr();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tranFlag = ($urandom_range(0, 2) == 0);
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_x     = 9'($urandom);
      wr_y     = 9'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      num      = 7'($urandom_range(0, 20));
      clr      = ($urandom_range(0, 31) == 0);
      tick();
    end
    tranFlag = 1'b0; wr_en = 1'b0; start = 1'b0; clr = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
